// File: rtl/uart_seq_framer.sv
// ----------------------------------------------------------------------------
// uart_seq_framer
//
// Purpose:
//   Frames byte traffic from a UART receiver into fixed-size word sequences
//   for an external sorter, then streams the sorted result back out to a UART
//   transmitter. Each frame consists of:
//     1. A header byte. Only bit 0 is used, as the sort direction
//        (1 = descending).
//     2. DEPTH*WIDTH/8 data bytes. Within each word the MSB byte comes first.
//        Word k lands in sort_data[k*WIDTH +: WIDTH].
//   Sequence of operations for one frame:
//     - The packed sequence is offered to the sorter.
//     - The sorted result is captured.
//     - The result is transmitted, word 0 first and MSB byte first.
//   After NUM_SEQ frames the block parks in DONE until reset.
//
// Optional feature:
//   FRAMER_CHECKSUM_EN -- when defined, an extra byte is transmitted after the
//   data bytes. It is the XOR of all transmitted data bytes. The sequence
//   counter then advances on the checksum handshake instead of the last data
//   byte.
//
// Parameters:
//   WIDTH    word width in bits (multiple of 8, 8..64)
//   DEPTH    words per sequence (power of 2, 2..64)
//   NUM_SEQ  number of sequences processed before completion
//
// Ports:
//   CLK100MHZ     in   single clock, rising edge
//   rst           in   asynchronous active-low reset
//   rx_valid      in   one-cycle strobe from the UART receiver
//   rx_byte       in   received byte
//   tx_byte       out  byte to the UART transmitter
//   tx_valid      out  tx_byte is valid
//   tx_ready      in   transmitter accepts tx_byte
//   sort_data     out  packed sequence for the sorter
//   sort_dir      out  sort direction (1 = descending)
//   sort_valid    out  sort_data is valid
//   sort_ready    in   sorter accepts the sequence
//   res_data      in   sorted result from the sorter
//   res_valid     in   res_data is valid
//   res_ready     out  framer can accept the result
//   seq_count     out  completed sequences
//   all_done      out  NUM_SEQ sequences completed
//   busy          out  frame in progress
//   overflow_err  out  sticky: a byte arrived while it could not be accepted
// ----------------------------------------------------------------------------
module uart_seq_framer #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int NUM_SEQ = 10
) (
  input  logic                         CLK100MHZ,
  input  logic                         rst,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_byte,
  output logic [7:0]                   tx_byte,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [WIDTH*DEPTH-1:0]       sort_data,
  output logic                         sort_dir,
  output logic                         sort_valid,
  input  logic                         sort_ready,
  input  logic [WIDTH*DEPTH-1:0]       res_data,
  input  logic                         res_valid,
  output logic                         res_ready,
  output logic [$clog2(NUM_SEQ+1)-1:0] seq_count,
  output logic                         all_done,
  output logic                         busy,
  output logic                         overflow_err
);

  localparam int BPW   = WIDTH / 8;        // bytes per word
  localparam int TOTAL = DEPTH * BPW;      // data bytes per frame
  localparam int SEQ_W = $clog2(NUM_SEQ + 1);
`ifdef FRAMER_CHECKSUM_EN
  localparam int TX_LEN = TOTAL + 1;       // data bytes plus checksum
`else
  localparam int TX_LEN = TOTAL;
`endif
  // Sized so the counter can hold TOTAL itself, which is the checksum slot.
  // The counter is cleared at every frame boundary, so it never wraps.
  localparam int CNT_W = $clog2(TOTAL + 1);

  localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(TX_LEN - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RX_WORDS = 3'd1,
    SORT_REQ = 3'd2,
    WAIT_RES = 3'd3,
    TX_WORDS = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic                     sort_dir_q;
  logic [WIDTH*DEPTH-1:0]   res_q;
  logic [SEQ_W-1:0]         seq_count_q;
  logic [SEQ_W-1:0]         seq_inc;
  logic                     overflow_q;
  logic [7:0]               data_byte;
  logic [7:0]               tx_cur;
  logic                     rx_take;
  logic                     tx_hs;
  logic                     tx_last_hs;
  logic [7:0]               res_bytes [TOTAL];
`ifdef FRAMER_CHECKSUM_EN
  logic [7:0]               chk_q;
`endif

  assign rx_take    = (state_q == RX_WORDS) && rx_valid;
  assign tx_hs      = (state_q == TX_WORDS) && tx_ready;
  assign tx_last_hs = tx_hs && (cnt_q == LAST_TX);
  assign seq_inc    = seq_count_q + SEQ_W'(1);

  // --------------------------------------------------------------------------
  // Byte lanes
  // --------------------------------------------------------------------------
  // Stream byte gi maps to a fixed bit offset in the packed vector. Word
  // gi/BPW; the MSB byte comes first inside each word. Each receive lane owns
  // its own register, so the packed output is a plain concatenation.
  for (genvar gi = 0; gi < TOTAL; gi++) begin : g_lane
    localparam int OFF = (gi / BPW) * WIDTH + (BPW - 1 - (gi % BPW)) * 8;
    logic [7:0] lane_q;

    always_ff @(posedge CLK100MHZ or negedge rst) begin
      if (!rst) begin
        lane_q <= '0;
      end else if (rx_take && (cnt_q == CNT_W'(gi))) begin
        lane_q <= rx_byte;
      end
    end

    assign sort_data[OFF +: 8] = lane_q;
    assign res_bytes[gi]       = res_q[OFF +: 8];
  end

  // Select the result byte at the current transmit position.
  always_comb begin
    data_byte = '0;
    for (int i = 0; i < TOTAL; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        data_byte = res_bytes[i];
      end
    end
  end

`ifdef FRAMER_CHECKSUM_EN
  assign tx_cur = (cnt_q == CNT_W'(TOTAL)) ? chk_q : data_byte;
`else
  assign tx_cur = data_byte;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK100MHZ or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rx_valid) state_d = RX_WORDS;
      end
      RX_WORDS: begin
        if (rx_valid && (cnt_q == LAST_RX)) state_d = SORT_REQ;
      end
      SORT_REQ: begin
        if (sort_ready) state_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (res_valid) state_d = TX_WORDS;
      end
      TX_WORDS: begin
        if (tx_last_hs) begin
          state_d = (seq_inc == SEQ_W'(NUM_SEQ)) ? DONE : IDLE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    sort_valid = 1'b0;
    res_ready  = 1'b0;
    tx_valid   = 1'b0;
    tx_byte    = '0;
    all_done   = 1'b0;
    busy       = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
      end
      SORT_REQ: begin
        sort_valid = 1'b1;
      end
      WAIT_RES: begin
        res_ready = 1'b1;
      end
      TX_WORDS: begin
        tx_valid = 1'b1;
        tx_byte  = tx_cur;
      end
      DONE: begin
        busy     = 1'b0;
        all_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK100MHZ or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      sort_dir_q  <= 1'b0;
      res_q       <= '0;
      seq_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (rx_valid) sort_dir_q <= rx_byte[0];
        end
        RX_WORDS: begin
          if (rx_valid) cnt_q <= (cnt_q == LAST_RX) ? '0 : cnt_q + CNT_W'(1);
        end
        WAIT_RES: begin
          if (res_valid) res_q <= res_data;
        end
        TX_WORDS: begin
          if (tx_ready) cnt_q <= (cnt_q == LAST_TX) ? '0 : cnt_q + CNT_W'(1);
          if (tx_last_hs) seq_count_q <= seq_inc;
        end
        default: begin
        end
      endcase

      // Bytes arriving while a frame cannot take them are dropped, and the
      // drop is flagged until reset.
      if (rx_valid && (state_q != IDLE) && (state_q != RX_WORDS)) begin
        overflow_q <= 1'b1;
      end
    end
  end

`ifdef FRAMER_CHECKSUM_EN
  // Running XOR of the data bytes as they are handed to the transmitter.
  // The accumulator is cleared when a new result is captured.
  always_ff @(posedge CLK100MHZ or negedge rst) begin
    if (!rst) begin
      chk_q <= '0;
    end else if ((state_q == WAIT_RES) && res_valid) begin
      chk_q <= '0;
    end else if (tx_hs && (cnt_q != CNT_W'(TOTAL))) begin
      chk_q <= chk_q ^ data_byte;
    end
  end
`endif

  assign sort_dir     = sort_dir_q;
  assign seq_count    = seq_count_q;
  assign overflow_err = overflow_q;

endmodule
